// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, control strobes and decoded position outputs
interface quad_decoder_if #(parameter int CNT_W = 8);
    logic a_in, b_in, clr_cnt, clr_err;
    logic ready, dir, step_up, step_dn, err;
    logic [CNT_W-1:0] count;
    modport master(output a_in, b_in, clr_cnt, clr_err,
                   input ready, count, dir, step_up, step_dn, err);
    modport slave(input a_in, b_in, clr_cnt, clr_err,
                  output ready, count, dir, step_up, step_dn, err);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised, glitch-filtered quadrature decoder with wrapping position count
module quad_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input logic clk,
    input logic reset,
    quad_decoder_if.slave bus
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0] sa, sb;
    logic [1:0] syn, filt, prev, pos_c, pos_p, delta;
    logic [FW-1:0] fcnt [2];
    logic [SW-1:0] st_cnt;
    logic up, dn, bad;
    assign syn = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};
    // Gray {A,B} -> position {A, A^B}; the modulo-4 difference classifies the move
    always_comb begin
        pos_c = {filt[1], ^filt};
        pos_p = {prev[1], ^prev};
        delta = pos_c - pos_p;
        up    = bus.ready && delta == 2'd1;
        dn    = bus.ready && delta == 2'd3;
        bad   = bus.ready && delta == 2'd2;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sa          <= '0;
            sb          <= '0;
            filt        <= '0;
            prev        <= '0;
            fcnt[0]     <= '0;
            fcnt[1]     <= '0;
            st_cnt      <= '0;
            bus.ready   <= 1'b0;
            bus.count   <= '0;
            bus.dir     <= 1'b1;
            bus.step_up <= 1'b0;
            bus.step_dn <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            sa <= {sa[SYNC_STAGES-2:0], bus.a_in};
            sb <= {sb[SYNC_STAGES-2:0], bus.b_in};
            // startup window: track the pins directly so a resting non-00 state is not an error
            if (!bus.ready) begin
                st_cnt    <= st_cnt + 1'b1;
                bus.ready <= st_cnt == SW'(SYNC_STAGES);
                filt      <= syn;
                prev      <= syn;
            end else begin
                prev <= filt;
                for (int i = 0; i < 2; i++)
                    if (syn[i] == filt[i]) fcnt[i] <= '0;
                    else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                        filt[i] <= syn[i];
                        fcnt[i] <= '0;
                    end else fcnt[i] <= fcnt[i] + 1'b1;
            end
            bus.step_up <= up;
            bus.step_dn <= dn;
            if (up || dn) bus.dir <= up;
            bus.count <= bus.clr_cnt ? '0 : up ? bus.count + 1'b1 : dn ? bus.count - 1'b1 : bus.count;
            bus.err   <= bad || (bus.err && !bus.clr_err);
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed vector table plus hand sequences for startup, glitch, error, clear and reset
module tb_quad_decoder;
    typedef struct packed {
        logic       a, b, up, dn;
        logic [7:0] cnt;
        logic       dir;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0, passed = 0;
    int n_up = 0, n_dn = 0, n_both = 0;
    int s_up, s_dn;
    vec_t tbl [12];
    quad_decoder_if #(.CNT_W(8)) bus();
    quad_decoder dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.step_up) n_up++;
        if (bus.step_dn) n_dn++;
        if (bus.step_up && bus.step_dn) n_both++;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic do_reset(input logic a, input logic b);
        reset = 1'b0;
        bus.a_in = a;
        bus.b_in = b;
        bus.clr_cnt = 1'b0;
        bus.clr_err = 1'b0;
        tick(3);
        chk("rst_ready", bus.ready, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_dir", bus.dir, 1);
        chk("rst_err", bus.err, 0);
        reset = 1'b1;
        tick(2);
        chk("startup_not_ready", bus.ready, 0);
        tick(1);
        chk("startup_ready", bus.ready, 1);
    endtask
    task automatic move(input vec_t v);
        bus.a_in = v.a;
        bus.b_in = v.b;
        tick(5);
        chk("early_pulse", {bus.step_up, bus.step_dn}, 0);
        tick(1);
        chk("pulse", {bus.step_up, bus.step_dn}, {v.up, v.dn});
        tick(1);
        chk("pulse_width", {bus.step_up, bus.step_dn}, 0);
        tick(3);
        chk("count", bus.count, v.cnt);
        chk("dir", bus.dir, v.dir);
        chk("no_err", bus.err, 0);
    endtask
    initial begin
        tbl = '{
            '{1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b1},
            '{1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 1'b1},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1}
        };
        // encoder resting at 11 through reset must not raise err or step
        s_up = n_up;
        s_dn = n_dn;
        do_reset(1'b1, 1'b1);
        tick(10);
        chk("rest11_err", bus.err, 0);
        chk("rest11_count", bus.count, 0);
        chk("rest11_pulses", n_up + n_dn - s_up - s_dn, 0);
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) move(tbl[i]);
        // 2-cycle glitch rejected, 3-cycle level accepted (down then back up)
        s_up = n_up;
        s_dn = n_dn;
        bus.a_in = 1'b1;
        tick(2);
        bus.a_in = 1'b0;
        tick(12);
        chk("glitch_pulses", n_up + n_dn - s_up - s_dn, 0);
        chk("glitch_count", bus.count, 0);
        bus.a_in = 1'b1;
        tick(3);
        bus.a_in = 1'b0;
        tick(15);
        chk("accept_dn", n_dn - s_dn, 1);
        chk("accept_up", n_up - s_up, 1);
        chk("accept_count", bus.count, 0);
        // illegal transitions and err clearing
        s_up = n_up;
        s_dn = n_dn;
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        tick(10);
        chk("illegal_err", bus.err, 1);
        chk("illegal_count", bus.count, 0);
        chk("illegal_dir", bus.dir, 1);
        chk("illegal_pulses", n_up + n_dn - s_up - s_dn, 0);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("clr_err", bus.err, 0);
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        tick(5);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("err_set_wins", bus.err, 1);
        tick(4);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("clr_err2", bus.err, 0);
        // clr_cnt coinciding with a step
        for (int i = 0; i < 5; i++) begin
            bus.a_in = tbl[i].a;
            bus.b_in = tbl[i].b;
            tick(10);
        end
        chk("pre_clr_count", bus.count, 5);
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        tick(5);
        bus.clr_cnt = 1'b1;
        tick(1);
        bus.clr_cnt = 1'b0;
        chk("clr_step_up", bus.step_up, 1);
        chk("clr_count", bus.count, 0);
        chk("clr_dir", bus.dir, 1);
        tick(4);
        // build non-reset state, then reset mid-step
        bus.a_in = 1'b0;
        tick(10);
        bus.b_in = 1'b0;
        tick(10);
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        tick(10);
        chk("pre_rst_count", bus.count, 8'hFE);
        chk("pre_rst_dir", bus.dir, 0);
        chk("pre_rst_err", bus.err, 1);
        bus.a_in = 1'b0;
        tick(3);
        reset = 1'b0;
        #1;
        chk("async_ready", bus.ready, 0);
        chk("async_count", bus.count, 0);
        chk("async_dir", bus.dir, 1);
        chk("async_err", bus.err, 0);
        chk("async_pulses", {bus.step_up, bus.step_dn}, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("restart_not_ready", bus.ready, 0);
        tick(1);
        chk("restart_ready", bus.ready, 1);
        tick(10);
        chk("restart_count", bus.count, 0);
        chk("restart_err", bus.err, 0);
        chk("never_both", n_both, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
